// File: rtl/i2c_slave.sv
// I2C target with a 7-bit address: accepts unlimited-length writes and serves reads
// from tx_data. SCL is only observed, so the clock is never stretched.
module i2c_slave #(
   parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i2c_scl,
   inout  wire        i2c_sda,
   input  logic [7:0] tx_data,
   output logic       tx_load,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       busy
);

   typedef enum logic [2:0] {
      IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
   } state_t;

   logic [1:0] scl_sync_q, sda_sync_q;
   logic       scl_dly_q, sda_dly_q;
   state_t     state_q, state_d;
   logic [2:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] tx_sr_q, tx_sr_d;
   logic [1:0] phase_q, phase_d;
   logic       sda_oe_q, sda_oe_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d;
   logic       tx_load_q, tx_load_d;

   logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

   assign scl_s     = scl_sync_q[1];
   assign sda_s     = sda_sync_q[1];
   assign scl_rise  = scl_s & ~scl_dly_q;
   assign scl_fall  = ~scl_s & scl_dly_q;
   assign start_det = scl_s & scl_dly_q & sda_dly_q & ~sda_s;
   assign stop_det  = scl_s & scl_dly_q & ~sda_dly_q & sda_s;

   assign i2c_sda  = sda_oe_q ? 1'b0 : 1'bz;
   assign rx_data  = rx_data_q;
   assign rx_valid = rx_valid_q;
   assign tx_load  = tx_load_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_dly_q  <= 1'b1;
         sda_dly_q  <= 1'b1;
         state_q    <= IDLE;
         bit_cnt_q  <= 3'd7;
         shift_q    <= '0;
         tx_sr_q    <= '0;
         phase_q    <= '0;
         sda_oe_q   <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         tx_load_q  <= 1'b0;
      end else begin
         scl_sync_q <= {scl_sync_q[0], i2c_scl};
         sda_sync_q <= {sda_sync_q[0], i2c_sda};
         scl_dly_q  <= scl_sync_q[1];
         sda_dly_q  <= sda_sync_q[1];
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         tx_sr_q    <= tx_sr_d;
         phase_q    <= phase_d;
         sda_oe_q   <= sda_oe_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         tx_load_q  <= tx_load_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      tx_sr_d    = tx_sr_q;
      phase_d    = phase_q;
      sda_oe_d   = sda_oe_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      tx_load_d  = 1'b0;

      if (stop_det) begin
         state_d  = IDLE;
         sda_oe_d = 1'b0;
      end else if (start_det) begin
         state_d   = ADDR;
         bit_cnt_d = 3'd7;
         phase_d   = '0;
         sda_oe_d  = 1'b0;
      end else begin
         case (state_q)
            ADDR: if (scl_rise) begin
               shift_d   = {shift_q[6:0], sda_s};
               bit_cnt_d = bit_cnt_q - 3'd1;
               if (bit_cnt_q == 3'd0) begin
                  phase_d = '0;
                  state_d = (shift_q[6:0] == SLAVE_ADDR) ? ADDR_ACK : WAIT_STOP;
               end
            end
            // phase 0: ACK-start fall, phase 1: ACK-end fall; shift_q[0] holds R/W
            ADDR_ACK: if (scl_fall) begin
               if (phase_q == 2'd0) begin
                  sda_oe_d = 1'b1;
                  phase_d  = 2'd1;
                  if (shift_q[0]) begin
                     tx_sr_d   = tx_data;
                     tx_load_d = 1'b1;
                  end
               end else begin
                  phase_d   = '0;
                  bit_cnt_d = 3'd7;
                  if (shift_q[0]) begin
                     state_d  = TX_BYTE;
                     sda_oe_d = ~tx_sr_q[7];
                     tx_sr_d  = {tx_sr_q[6:0], 1'b0};
                  end else begin
                     state_d  = RX_BYTE;
                     sda_oe_d = 1'b0;
                  end
               end
            end
            RX_BYTE: if (scl_rise) begin
               shift_d   = {shift_q[6:0], sda_s};
               bit_cnt_d = bit_cnt_q - 3'd1;
               if (bit_cnt_q == 3'd0) begin
                  rx_data_d  = {shift_q[6:0], sda_s};
                  rx_valid_d = 1'b1;
                  phase_d    = '0;
                  state_d    = RX_ACK;
               end
            end
            RX_ACK: if (scl_fall) begin
               if (phase_q == 2'd0) begin
                  sda_oe_d = 1'b1;
                  phase_d  = 2'd1;
               end else begin
                  sda_oe_d = 1'b0;
                  phase_d  = '0;
                  state_d  = RX_BYTE;
               end
            end
            // MSB is already on the bus on entry; falls here drive bits 6..0
            TX_BYTE: begin
               if (scl_fall) begin
                  sda_oe_d = ~tx_sr_q[7];
                  tx_sr_d  = {tx_sr_q[6:0], 1'b0};
               end
               if (scl_rise) begin
                  bit_cnt_d = bit_cnt_q - 3'd1;
                  if (bit_cnt_q == 3'd0) begin
                     phase_d = '0;
                     state_d = TX_ACK;
                  end
               end
            end
            TX_ACK: begin
               case (phase_q)
                  2'd0: if (scl_fall) begin
                     sda_oe_d = 1'b0;
                     phase_d  = 2'd1;
                  end
                  2'd1: if (scl_rise) begin
                     if (sda_s) state_d = WAIT_STOP;
                     else       phase_d = 2'd2;
                  end
                  default: if (scl_fall) begin
                     tx_load_d = 1'b1;
                     sda_oe_d  = ~tx_data[7];
                     tx_sr_d   = {tx_data[6:0], 1'b0};
                     bit_cnt_d = 3'd7;
                     phase_d   = '0;
                     state_d   = TX_BYTE;
                  end
               endcase
            end
            default: sda_oe_d = 1'b0;
         endcase
      end
   end

   always_comb begin
      case (state_q)
         ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK: busy = 1'b1;
         default:                                    busy = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged bus master plus a transaction-level model of
// what the target must do, checked every settled cycle and at scenario ends.
module tb_i2c_slave;

   localparam logic [6:0] ADDR = 7'h50;
   localparam int Q = 8;
   localparam time SETTLE = 60;

   typedef enum {M_IDLE, M_ADDR, M_WR, M_RD} mmode_t;

   logic clk = 1'b0, rst = 1'b1, m_scl = 1'b1, m_sda = 1'b1;
   logic [7:0] tx_data = 8'h00;
   wire  sda_bus;
   logic tx_load, rx_valid, busy;
   logic [7:0] rx_data;

   assign sda_bus = m_sda ? 1'bz : 1'b0;
   pullup (sda_bus);

   i2c_slave #(.SLAVE_ADDR(ADDR)) dut (
      .clk(clk), .rst(rst), .i2c_scl(m_scl), .i2c_sda(sda_bus),
      .tx_data(tx_data), .tx_load(tx_load), .rx_data(rx_data),
      .rx_valid(rx_valid), .busy(busy)
   );

   always #5 clk = ~clk;

   time  last_chg = 0;
   bit   chk_on = 1'b0;
   int   n_chk = 0, n_pass = 0;
   int   rxv_seen = 0, txl_seen = 0, exp_rx = 0, exp_txl = 0, acks = 0;
   logic exp_busy = 1'b0, exp_dut_low = 1'b0, pend_ack = 1'b0;
   logic [7:0] exp_rx_data = 8'h00, tx_shadow = 8'h00;
   mmode_t mode = M_IDLE;
   logic [7:0] rx_log[$];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      else n_pass++;
   endtask

   always @(negedge clk) begin
      if (rx_valid) begin
         rxv_seen++;
         rx_log.push_back(rx_data);
      end
      if (tx_load) txl_seen++;
      if (chk_on && !rst && ($time - last_chg) >= SETTLE) begin
         chk("busy", int'(busy), int'(exp_busy));
         chk("rx_data", int'(rx_data), int'(exp_rx_data));
         chk("sda", int'(sda_bus), int'(m_sda & ~exp_dut_low));
      end
   end

   task automatic wait_q(input int n);
      repeat (n * Q) @(negedge clk);
   endtask

   task automatic set_bus(input logic scl, input logic sda);
      m_scl = scl;
      m_sda = sda;
      last_chg = $time;
   endtask

   task automatic byte_done(input logic [7:0] b);
      pend_ack = 1'b0;
      case (mode)
         M_ADDR: if (b[7:1] == ADDR) begin
            pend_ack = 1'b1;
            exp_busy = 1'b1;
            mode = b[0] ? M_RD : M_WR;
         end else mode = M_IDLE;
         M_WR: begin
            pend_ack = 1'b1;
            exp_rx_data = b;
            exp_rx++;
         end
         default: ;
      endcase
   endtask

   task automatic send_bits(input logic [7:0] b, input int n);
      logic v;
      for (int k = 0; k < n; k++) begin
         v = b[7-k];
         set_bus(1'b0, v); wait_q(1);
         set_bus(1'b1, v);
         if (k == 7) byte_done(b);
         wait_q(2);
         set_bus(1'b0, v);
         if (k == 7) begin
            exp_dut_low = pend_ack;
            if (pend_ack && mode == M_RD) begin
               tx_shadow = tx_data;
               exp_txl++;
            end
         end
         wait_q(1);
      end
   endtask

   task automatic ack_slot();
      logic got;
      set_bus(1'b0, 1'b1); wait_q(1);
      set_bus(1'b1, 1'b1); wait_q(1);
      got = sda_bus;
      chk("ack", int'(got), int'(!pend_ack));
      if (!got) acks++;
      wait_q(1);
      set_bus(1'b0, 1'b1);
      exp_dut_low = (pend_ack && mode == M_RD) ? !tx_shadow[7] : 1'b0;
      wait_q(1);
   endtask

   task automatic read_byte(input logic mack, output logic [7:0] got);
      for (int i = 7; i >= 0; i--) begin
         set_bus(1'b0, 1'b1); wait_q(1);
         set_bus(1'b1, 1'b1); wait_q(1);
         got[i] = sda_bus;
         wait_q(1);
         set_bus(1'b0, 1'b1);
         exp_dut_low = (i > 0) ? !tx_shadow[i-1] : 1'b0;
         wait_q(1);
      end
      chk("rd_byte", int'(got), int'(tx_shadow));
      set_bus(1'b0, mack); wait_q(1);
      set_bus(1'b1, mack);
      if (mack) begin
         exp_busy = 1'b0;
         mode = M_IDLE;
      end
      wait_q(2);
      set_bus(1'b0, mack);
      if (!mack) begin
         tx_shadow = tx_data;
         exp_txl++;
         exp_dut_low = !tx_shadow[7];
      end
      wait_q(1);
   endtask

   task automatic do_start();
      if (!m_scl) begin
         set_bus(1'b0, 1'b1); wait_q(1);
         set_bus(1'b1, 1'b1); wait_q(1);
      end
      set_bus(1'b1, 1'b0);
      mode = M_ADDR;
      exp_busy = 1'b0;
      exp_dut_low = 1'b0;
      pend_ack = 1'b0;
      wait_q(1);
      set_bus(1'b0, 1'b0); wait_q(1);
   endtask

   task automatic do_stop();
      set_bus(1'b0, 1'b0); wait_q(1);
      set_bus(1'b1, 1'b0); wait_q(1);
      set_bus(1'b1, 1'b1);
      mode = M_IDLE;
      exp_busy = 1'b0;
      exp_dut_low = 1'b0;
      wait_q(2);
   endtask

   initial begin
      int r0, t0, a0, qi;
      logic [7:0] g;
      logic [7:0] mb [4];
      mb = '{8'h00, 8'hFF, 8'h55, 8'hAA};

      repeat (4) @(negedge clk);
      chk("rst_busy", int'(busy), 0);
      chk("rst_rx_data", int'(rx_data), 0);
      chk("rst_rx_valid", int'(rx_valid), 0);
      chk("rst_tx_load", int'(tx_load), 0);
      chk("rst_sda", int'(sda_bus), 1);
      rst = 1'b0;
      last_chg = $time;
      chk_on = 1'b1;
      wait_q(1);

      // single-byte write
      r0 = rxv_seen; a0 = acks;
      do_start();
      send_bits(8'hA0, 8); ack_slot();
      send_bits(8'h3C, 8); ack_slot();
      do_stop();
      chk("wr_rx_data", int'(rx_data), 32'h3C);
      chk("wr_rxv_pulses", rxv_seen - r0, 1);
      chk("wr_acks", acks - a0, 2);
      chk("wr_busy_after_stop", int'(busy), 0);

      // two-byte read, master ACKs then NACKs
      tx_data = 8'h96;
      t0 = txl_seen;
      do_start();
      send_bits(8'hA1, 8); ack_slot();
      tx_data = 8'h5A;
      read_byte(1'b0, g);
      chk("rd_byte0", int'(g), 32'h96);
      read_byte(1'b1, g);
      chk("rd_byte1", int'(g), 32'h5A);
      wait_q(1);
      chk("rd_nack_release", int'(sda_bus), 1);
      do_stop();
      chk("rd_tx_load_pulses", txl_seen - t0, 2);

      // address mismatch
      r0 = rxv_seen; a0 = acks;
      do_start();
      send_bits(8'hB0, 8); ack_slot();
      send_bits(8'h11, 8); ack_slot();
      do_stop();
      chk("mis_rxv_pulses", rxv_seen - r0, 0);
      chk("mis_acks", acks - a0, 0);

      // repeated START four bits into the second data byte
      tx_data = 8'h33;
      r0 = rxv_seen; a0 = acks;
      do_start();
      send_bits(8'hA0, 8); ack_slot();
      send_bits(8'h01, 8); ack_slot();
      send_bits(8'hC0, 4);
      do_start();
      send_bits(8'hA1, 8); ack_slot();
      read_byte(1'b1, g);
      chk("rs_read", int'(g), 32'h33);
      do_stop();
      chk("rs_rxv_pulses", rxv_seen - r0, 1);
      chk("rs_rx_data", int'(rx_data), 32'h01);
      chk("rs_acks", acks - a0, 3);

      // reset while the address ACK is on the bus
      do_start();
      send_bits(8'hA0, 8);
      set_bus(1'b0, 1'b1); wait_q(1);
      chk("rst_ack_low", int'(sda_bus), 0);
      @(negedge clk);
      rst = 1'b1;
      mode = M_IDLE; exp_busy = 1'b0; exp_dut_low = 1'b0; exp_rx_data = 8'h00;
      last_chg = $time;
      @(posedge clk); #1;
      chk("rst_mid_sda", int'(sda_bus), 1);
      chk("rst_mid_busy", int'(busy), 0);
      @(negedge clk);
      rst = 1'b0;
      last_chg = $time;
      wait_q(1);
      set_bus(1'b1, 1'b1); wait_q(2);
      set_bus(1'b0, 1'b1); wait_q(1);
      r0 = rxv_seen; a0 = acks;
      send_bits(8'hA0, 8); ack_slot();
      send_bits(8'h77, 8); ack_slot();
      do_stop();
      chk("post_rst_rxv", rxv_seen - r0, 0);
      chk("post_rst_acks", acks - a0, 0);
      chk("post_rst_rx_data", int'(rx_data), 0);

      // multi-byte write
      r0 = rxv_seen; a0 = acks; qi = rx_log.size();
      do_start();
      send_bits(8'hA0, 8); ack_slot();
      for (int j = 0; j < 4; j++) begin
         send_bits(mb[j], 8);
         ack_slot();
      end
      do_stop();
      chk("mb_rxv_pulses", rxv_seen - r0, 4);
      chk("mb_acks", acks - a0, 5);
      for (int j = 0; j < 4; j++)
         chk("mb_rx_order", (qi + j < rx_log.size()) ? int'(rx_log[qi+j]) : -1, int'(mb[j]));

      chk("total_rxv", rxv_seen, exp_rx);
      chk("total_tx_load", txl_seen, exp_txl);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
